rgb_hue_sequencer: RTL and testbench

//  Sequences the three LED PWM channels (R, G, B) through a six-phase hue wheel.
//  In each phase one channel ramps linearly while the other two hold their level.

---
 rtl/rgb_hue_sequencer.sv | 118 +++++++++++
 tb/tb_rgb_hue_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rgb_hue_sequencer.sv
// Six-phase RGB hue wheel: one channel ramps per phase while the other two hold,
// with a shared free-running PWM counter driving the LED pins.
module rgb_hue_sequencer #(
  parameter int unsigned PWM_MAX  = 1000,
  parameter int unsigned TICK_DIV = 2000,
  localparam int unsigned DW = $clog2(PWM_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic [2:0]    phase,
  output logic          phase_done,
  output logic          led_r,
  output logic          led_g,
  output logic          led_b
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = (PWM_MAX > 1) ? $clog2(PWM_MAX) : 1;
  localparam logic [DW-1:0] MAXV     = DW'(PWM_MAX);
  localparam logic [TW-1:0] TICK_END = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PWM_END  = PW'(PWM_MAX - 1);

  typedef enum logic [2:0] {
    P0_G_UP = 3'd0,
    P1_R_DN = 3'd1,
    P2_B_UP = 3'd2,
    P3_G_DN = 3'd3,
    P4_R_UP = 3'd4,
    P5_B_DN = 3'd5
  } phase_e;

  phase_e        phase_q;
  logic          phase_done_q;
  logic [DW-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic [TW-1:0] tick_cnt_q;
  logic [PW-1:0] pwm_cnt_q;

  logic          sel_r, sel_g, sel_b, ramp_up, at_end;
  logic [DW-1:0] cur_duty, step_d;
  phase_e        phase_d;

  // Active channel, ramp direction and successor phase from the phase table
  always_comb begin
    sel_r   = 1'b0;
    sel_g   = 1'b0;
    sel_b   = 1'b0;
    ramp_up = 1'b0;
    phase_d = P0_G_UP;
    unique case (phase_q)
      P0_G_UP: begin sel_g = 1'b1; ramp_up = 1'b1; phase_d = P1_R_DN; end
      P1_R_DN: begin sel_r = 1'b1; ramp_up = 1'b0; phase_d = P2_B_UP; end
      P2_B_UP: begin sel_b = 1'b1; ramp_up = 1'b1; phase_d = P3_G_DN; end
      P3_G_DN: begin sel_g = 1'b1; ramp_up = 1'b0; phase_d = P4_R_UP; end
      P4_R_UP: begin sel_r = 1'b1; ramp_up = 1'b1; phase_d = P5_B_DN; end
      P5_B_DN: begin sel_b = 1'b1; ramp_up = 1'b0; phase_d = P0_G_UP; end
      default: begin sel_g = 1'b1; ramp_up = 1'b1; phase_d = P1_R_DN; end
    endcase

    cur_duty = '0;
    if (sel_r) cur_duty = duty_r_q;
    if (sel_g) cur_duty = duty_g_q;
    if (sel_b) cur_duty = duty_b_q;

    // Saturating step keeps every duty inside 0..PWM_MAX
    if (ramp_up) begin
      step_d = (cur_duty >= MAXV) ? MAXV : cur_duty + 1'b1;
      at_end = (step_d == MAXV);
    end else begin
      step_d = (cur_duty == '0) ? '0 : cur_duty - 1'b1;
      at_end = (step_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= P0_G_UP;
      phase_done_q <= 1'b0;
      duty_r_q     <= MAXV;
      duty_g_q     <= '0;
      duty_b_q     <= '0;
      tick_cnt_q   <= '0;
      pwm_cnt_q    <= '0;
    end else begin
      pwm_cnt_q    <= (pwm_cnt_q == PWM_END) ? '0 : pwm_cnt_q + 1'b1;
      phase_done_q <= 1'b0;
      if (en) begin
        if (tick_cnt_q == TICK_END) begin
          tick_cnt_q <= '0;
          if (sel_r) duty_r_q <= step_d;
          if (sel_g) duty_g_q <= step_d;
          if (sel_b) duty_b_q <= step_d;
          if (at_end) begin
            phase_q      <= phase_d;
            phase_done_q <= 1'b1;
          end
        end else begin
          tick_cnt_q <= tick_cnt_q + 1'b1;
        end
      end
    end
  end

  assign duty_r     = duty_r_q;
  assign duty_g     = duty_g_q;
  assign duty_b     = duty_b_q;
  assign phase      = phase_q;
  assign phase_done = phase_done_q;

  // Counter never exceeds PWM_MAX-1, so duty PWM_MAX is solid on and 0 solid off
  assign led_r = (DW'(pwm_cnt_q) < duty_r_q);
  assign led_g = (DW'(pwm_cnt_q) < duty_g_q);
  assign led_b = (DW'(pwm_cnt_q) < duty_b_q);

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Directed plus randomized bench for rgb_hue_sequencer against a model that
// derives the full output state from the count of enabled clocks since reset.
module tb_rgb_hue_sequencer;

  localparam int unsigned PM = 4;
  localparam int unsigned TD = 2;
  localparam int unsigned PT = PM * TD;
  localparam int unsigned DW = $clog2(PM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic [2:0]    phase;
  logic          phase_done, led_r, led_g, led_b;

  rgb_hue_sequencer #(.PWM_MAX(PM), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .phase(phase), .phase_done(phase_done),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: enabled clocks into the current wheel turn, clocks since reset
  int unsigned m_en_cnt = 0;
  int unsigned m_cyc    = 0;
  bit          m_pd     = 1'b0;
  int          pulses   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge(input bit r, input bit e);
    if (r) begin
      m_en_cnt = 0;
      m_cyc    = 0;
      m_pd     = 1'b0;
    end else begin
      m_cyc++;
      m_pd = 1'b0;
      if (e) begin
        m_en_cnt++;
        m_pd     = (m_en_cnt % PT) == 0;
        m_en_cnt = m_en_cnt % (6 * PT);
      end
    end
  endtask

  task automatic check_all();
    int unsigned ph, k, er, eg, eb, pc;
    ph = m_en_cnt / PT;
    k  = (m_en_cnt % PT) / TD;
    er = 0; eg = 0; eb = 0;
    case (ph)
      0: begin er = PM;     eg = k;      eb = 0;      end
      1: begin er = PM - k; eg = PM;     eb = 0;      end
      2: begin er = 0;      eg = PM;     eb = k;      end
      3: begin er = 0;      eg = PM - k; eb = PM;     end
      4: begin er = k;      eg = 0;      eb = PM;     end
      default: begin er = PM; eg = 0;    eb = PM - k; end
    endcase
    pc = m_cyc % PM;
    chk("duty_r", 32'(duty_r), er);
    chk("duty_g", 32'(duty_g), eg);
    chk("duty_b", 32'(duty_b), eb);
    chk("phase", 32'(phase), ph);
    chk("phase_done", 32'(phase_done), 32'(m_pd));
    chk("led_r", 32'(led_r), 32'(pc < er));
    chk("led_g", 32'(led_g), 32'(pc < eg));
    chk("led_b", 32'(led_b), 32'(pc < eb));
    if (phase_done === 1'b1) pulses++;
  endtask

  task automatic step(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    model_edge(r, e);
    #1;
    check_all();
  endtask

  initial begin
    // Reset, then idle: led_r solid on, green/blue solid off
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("idle_phase", 32'(phase), 0);

    // Full wheel from reset: six pulses, back to (PM,0,0)
    step(1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b0, 1'b1);
      if (i == 7) begin
        chk("first_advance_phase", 32'(phase), 1);
        chk("first_advance_duty_g", 32'(duty_g), PM);
      end
    end
    chk("wheel_pulses", 32'(pulses), 6);
    chk("wheel_end_r", 32'(duty_r), PM);
    chk("wheel_end_g", 32'(duty_g), 0);

    // Freeze for 10 clocks after 3 enabled ones; P1 reached after 8 enabled total
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1);
    chk("resume_not_yet", 32'(phase), 0);
    step(1'b0, 1'b1);
    chk("resume_phase", 32'(phase), 1);
    chk("resume_pulse", 32'(phase_done), 1);

    // Frozen at duty_g=2: led_g follows 1,1,0,0 with the PWM counter
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1);
    chk("freeze_duty_g", 32'(duty_g), 2);
    for (int i = 0; i < 8; i++)  step(1'b0, 1'b0);

    // Reset beats enable mid-step in P3
    step(1'b1, 1'b0);
    for (int i = 0; i < 3 * PT + 3; i++) step(1'b0, 1'b1);
    chk("pre_abort_phase", 32'(phase), 3);
    step(1'b1, 1'b1);
    chk("abort_tick", 32'(dut.tick_cnt_q), 0);
    chk("abort_pwm", 32'(dut.pwm_cnt_q), 0);

    // Random enable with occasional resets
    step(1'b0, 1'b0);
    for (int i = 0; i < 3000; i++)
      step(($urandom % 250) == 0, ($urandom % 4) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
